// File: rtl/fetch_unit.sv
// fetch_unit
// ----------
// Instruction-fetch stage that sits directly in front of the main decoder.
// It owns the PC, fetches one word per instruction from instruction memory,
// registers it, and offers it to decode. While the word is held, it applies
// the next-PC decision from decode/execute: PC+4, or a branch/jump target.
//
// Handshake (imem side): imem_req is the request "valid". imem_addr is
// stable for as long as imem_req is high. A transfer completes on a rising
// edge where imem_req=1 and imem_ready=1, and imem_rdata is captured on that
// same edge. imem_ready while imem_req=0 has no effect. Each fetch issues
// exactly one request and takes exactly one word. The PC never changes while
// a request is outstanding.
//
// Ports:
//   clk         in   clock, all state changes on the rising edge
//   reset       in   synchronous active-high reset
//   PCSrc       in   1 = next PC is PCTarget; only sampled in HOLD without stall
//   PCTarget    in   branch/jump target from execute
//   stall_in    in   downstream stall, freezes HOLD
//   imem_req    out  instruction-memory request
//   imem_addr   out  fetch address (= PC)
//   imem_rdata  in   instruction word, valid when imem_ready=1
//   imem_ready  in   memory completes the request this cycle
//   Instr       out  registered instruction
//   op          out  Instr[6:0] for the main decoder
//   PC          out  address of Instr
//   PCPlus4     out  PC+4, wraps modulo 2^XLEN
//   instr_valid out  Instr/op valid for decode this cycle
//   fetch_err   out  sticky error: misaligned next PC or memory timeout
//   fetchState  out  current FSM state (debug observation)

module fetch_unit #(
    parameter int unsigned    XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned    MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    input  logic            stall_in,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ready,
    output logic [XLEN-1:0] Instr,
    output logic [6:0]      op,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            instr_valid,
    output logic            fetch_err,
    output logic [1:0]      fetchState
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        HOLD = 2'd1,
        ERR  = 2'd2
    } fetchState_t;

    // addi x0, x0, 0: a harmless word for decode to see after reset
    localparam logic [XLEN-1:0] NOP_WORD = XLEN'(32'h0000_0013);
    localparam logic [7:0]      WAIT_LAST = 8'(MAX_WAIT - 1);

    fetchState_t     stateQ,   stateD;
    logic [XLEN-1:0] pcQ,      pcD;
    logic [XLEN-1:0] instrQ,   instrD;
    logic [7:0]      waitCntQ, waitCntD;
    logic            errQ,     errD;

    logic [XLEN-1:0] pcPlus4;
    logic [XLEN-1:0] nextPc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // Any outstanding request is simply dropped: the state moves back
            // to REQ, so a ready seen on this edge is never captured.
            stateQ   <= REQ;
            pcQ      <= RESET_PC;
            instrQ   <= NOP_WORD;
            waitCntQ <= 8'd0;
            errQ     <= 1'b0;
        end else begin
            stateQ   <= stateD;
            pcQ      <= pcD;
            instrQ   <= instrD;
            waitCntQ <= waitCntD;
            errQ     <= errD;
        end
    end

    // ------------------------------------------------------------------
    // Next-PC candidates
    // ------------------------------------------------------------------
    assign pcPlus4 = pcQ + XLEN'(4);
    assign nextPc  = PCSrc ? PCTarget : pcPlus4;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        stateD   = stateQ;
        pcD      = pcQ;
        instrD   = instrQ;
        waitCntD = waitCntQ;
        errD     = errQ;

        case (stateQ)
            REQ: begin
                if (imem_ready) begin
                    instrD   = imem_rdata;
                    waitCntD = 8'd0;
                    stateD   = HOLD;
                end else if (waitCntQ == WAIT_LAST) begin
                    // This is the last allowed REQ cycle without a response.
                    errD   = 1'b1;
                    stateD = ERR;
                end else begin
                    waitCntD = waitCntQ + 8'd1;
                end
            end

            HOLD: begin
                if (!stall_in) begin
                    if (nextPc[1:0] != 2'b00) begin
                        // Keep the PC of the faulting instruction visible.
                        errD   = 1'b1;
                        stateD = ERR;
                    end else begin
                        pcD    = nextPc;
                        stateD = REQ;
                    end
                end
            end

            ERR: begin
                // Terminal until reset: all registers hold.
            end

            default: begin
                stateD = ERR;
                errD   = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req    = (stateQ == REQ)  && !reset;
    assign instr_valid = (stateQ == HOLD) && !reset;
    assign imem_addr   = pcQ;
    assign PC          = pcQ;
    assign PCPlus4     = pcPlus4;
    assign Instr       = instrQ;
    assign op          = instrQ[6:0];
    assign fetch_err   = errQ;
    assign fetchState  = stateQ;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: reset, zero-wait fetch, branch,
// wait states, stall, mid-request reset, misaligned target, PC wrap and
// memory timeout. Inputs change on the falling edge. Outputs are checked
// 1 ns later, well away from the rising edge.

module tb_fetch_unit;

    localparam int XLEN = 32;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    logic            clk;
    logic            reset;
    logic            PCSrc;
    logic [XLEN-1:0] PCTarget;
    logic            stall_in;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_ready;
    logic [XLEN-1:0] Instr;
    logic [6:0]      op;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] PCPlus4;
    logic            instr_valid;
    logic            fetch_err;
    logic [1:0]      fetchState;

    int compared   = 0;
    int mismatched = 0;

    // Words handed to memory, in the order they must show up on Instr
    logic [XLEN-1:0] exp_q[$];

    fetch_unit #(
        .XLEN    (32),
        .RESET_PC(32'h0000_0000),
        .MAX_WAIT(15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PCSrc      (PCSrc),
        .PCTarget   (PCTarget),
        .stall_in   (stall_in),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .Instr      (Instr),
        .op         (op),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .instr_valid(instr_valid),
        .fetch_err  (fetch_err),
        .fetchState (fetchState)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One rising edge; inputs may then be changed and outputs are checked at +1.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Zero-wait fetch from a REQ cycle: complete it and check the capture.
    task automatic doFetch(input logic [31:0] word, input logic [31:0] pcExp);
        logic [31:0] want;
        checkVal("fetch_req", {31'd0, imem_req}, 32'd1);
        checkVal("fetch_addr", imem_addr, pcExp);
        imem_ready = 1'b1;
        imem_rdata = word;
        exp_q.push_back(word);
        step();
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        checkVal("hold_valid", {31'd0, instr_valid}, 32'd1);
        checkVal("hold_instr", Instr, want);
        checkVal("hold_pc", PC, pcExp);
    endtask

    // Leave HOLD with the given next-PC decision.
    task automatic advance(input logic src, input logic [31:0] target);
        PCSrc    = src;
        PCTarget = target;
        step();
        PCSrc    = 1'b0;
        PCTarget = 32'h0;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        #1;
        checkVal("rst_req_forced", {31'd0, imem_req}, 32'd0);
        checkVal("rst_valid_forced", {31'd0, instr_valid}, 32'd0);
        step();
        reset = 1'b0;
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b1;
        PCSrc      = 1'b0;
        PCTarget   = 32'h0;
        stall_in   = 1'b0;
        imem_rdata = 32'h0;
        imem_ready = 1'b1;  // stale ready during reset must be ignored

        // Reset state
        step();
        step();
        checkVal("rst_req", {31'd0, imem_req}, 32'd0);
        checkVal("rst_valid", {31'd0, instr_valid}, 32'd0);
        checkVal("rst_pc", PC, 32'h0);
        checkVal("rst_instr", Instr, 32'h0000_0013);
        checkVal("rst_err", {31'd0, fetch_err}, 32'd0);
        checkVal("rst_state", {30'd0, fetchState}, {30'd0, ST_REQ});
        imem_ready = 1'b0;
        reset      = 1'b0;
        #1;

        // Cycle 1 after release: request at 0, capture, decode, then addr 4
        checkVal("c1_req", {31'd0, imem_req}, 32'd1);
        checkVal("c1_addr", imem_addr, 32'h0);
        doFetch(32'h0050_0093, 32'h0);
        checkVal("c2_op", {25'd0, op}, {25'd0, 7'b0010011});
        checkVal("c2_pcplus4", PCPlus4, 32'h4);
        advance(1'b0, 32'h0);
        checkVal("c3_addr", imem_addr, 32'h4);
        checkVal("c3_valid", {31'd0, instr_valid}, 32'd0);

        // Walk sequentially up to PC 0x10
        doFetch(32'h0000_0013, 32'h4);  advance(1'b0, 32'h0);
        doFetch(32'h0010_8093, 32'h8);  advance(1'b0, 32'h0);
        doFetch(32'h0020_8113, 32'hC);  advance(1'b0, 32'h0);

        // Branch from 0x10 to 0x40
        doFetch(32'h0300_006F, 32'h10);
        advance(1'b1, 32'h40);
        checkVal("br_addr", imem_addr, 32'h40);
        doFetch(32'h0000_0033, 32'h40);
        checkVal("br_pcplus4", PCPlus4, 32'h44);
        advance(1'b0, 32'h0);

        // Three wait cycles at 0x44, ready on the fourth request cycle
        for (int i = 0; i < 3; i++) begin
            checkVal("ws_req", {31'd0, imem_req}, 32'd1);
            checkVal("ws_addr", imem_addr, 32'h44);
            imem_rdata = 32'hBAD0_0000 + 32'(i);
            step();
            checkVal("ws_instr_held", Instr, 32'h0000_0033);
        end
        doFetch(32'h00A0_0113, 32'h44);
        checkVal("ws_err", {31'd0, fetch_err}, 32'd0);

        // Stall for 5 cycles in HOLD with PCSrc toggling
        stall_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            PCSrc    = i[0];
            PCTarget = 32'h80;
            step();
            checkVal("st_valid", {31'd0, instr_valid}, 32'd1);
            checkVal("st_instr", Instr, 32'h00A0_0113);
            checkVal("st_pc", PC, 32'h44);
        end
        stall_in = 1'b0;
        advance(1'b0, 32'h0);
        checkVal("st_release_pc", PC, 32'h48);
        checkVal("st_release_req", {31'd0, imem_req}, 32'd1);

        // Reset in the middle of a waiting request; ready arrives during reset
        step();
        step();
        checkVal("mid_wait_req", {31'd0, imem_req}, 32'd1);
        imem_ready = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        pulseReset();
        imem_ready = 1'b0;
        checkVal("mid_instr", Instr, 32'h0000_0013);
        checkVal("mid_pc", PC, 32'h0);
        checkVal("mid_valid", {31'd0, instr_valid}, 32'd0);
        checkVal("mid_req_after", {31'd0, imem_req}, 32'd1);

        // Misaligned branch target
        doFetch(32'h1000_0063, 32'h0);
        advance(1'b1, 32'h102);
        checkVal("mis_err", {31'd0, fetch_err}, 32'd1);
        checkVal("mis_req", {31'd0, imem_req}, 32'd0);
        checkVal("mis_pc", PC, 32'h0);
        checkVal("mis_state", {30'd0, fetchState}, {30'd0, ST_ERR});
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5678;
        step();
        step();
        imem_ready = 1'b0;
        checkVal("mis_err_sticky", {31'd0, fetch_err}, 32'd1);
        checkVal("mis_no_capture", Instr, 32'h1000_0063);
        checkVal("mis_valid", {31'd0, instr_valid}, 32'd0);
        pulseReset();
        checkVal("mis_rst_err", {31'd0, fetch_err}, 32'd0);
        checkVal("mis_rst_pc", PC, 32'h0);
        checkVal("mis_rst_req", {31'd0, imem_req}, 32'd1);

        // PC wrap at the top of the address space
        doFetch(32'h0000_0013, 32'h0);
        advance(1'b1, 32'hFFFF_FFFC);
        doFetch(32'h0000_0013, 32'hFFFF_FFFC);
        checkVal("wrap_pcplus4", PCPlus4, 32'h0);
        advance(1'b0, 32'h0);
        checkVal("wrap_addr", imem_addr, 32'h0);
        checkVal("wrap_state", {30'd0, fetchState}, {30'd0, ST_REQ});

        // Timeout: ready never asserted, error after the 15th request cycle
        for (int i = 0; i < 15; i++) begin
            checkVal("to_req", {31'd0, imem_req}, 32'd1);
            checkVal("to_err_pending", {31'd0, fetch_err}, 32'd0);
            step();
        end
        checkVal("to_err", {31'd0, fetch_err}, 32'd1);
        checkVal("to_req_off", {31'd0, imem_req}, 32'd0);
        checkVal("to_state", {30'd0, fetchState}, {30'd0, ST_ERR});
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        checkVal("to_held_state", {30'd0, fetchState}, {30'd0, ST_ERR});
        checkVal("to_held_instr", Instr, 32'h0000_0013);
        pulseReset();
        checkVal("to_rst_err", {31'd0, fetch_err}, 32'd0);
        checkVal("to_rst_state", {30'd0, fetchState}, {30'd0, ST_HOLD - 2'd1});

        checkVal("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the main decoder in the single-cycle RISC-V core. Owns the PC and runs a request/ready handshake to instruction memory. Registers the returned word and presents it with op = instr[6:0] to the decoder. Applies the next-PC decision (PC+4 or branch/jump target) that decode/execute returns while the instruction is held.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, PC value loaded on reset
MAX_WAIT, 15, maximum number of REQ cycles without imem_ready before a timeout error (range 1..255)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
PCSrc  in  1  1 = take PCTarget; sampled only in HOLD when stall_in=0
PCTarget  in  XLEN  branch/jump target from execute
stall_in  in  1  downstream stall; freezes HOLD
imem_req  out  1  instruction-memory request
imem_addr  out  XLEN  fetch address (= PC)
imem_rdata  in  XLEN  instruction word; valid when imem_ready=1
imem_ready  in  1  memory completes the request this cycle
Instr  out  XLEN  registered instruction
op  out  7  Instr[6:0], combinational, to the main decoder
PC  out  XLEN  address of Instr
PCPlus4  out  XLEN  PC+4, combinational
instr_valid  out  1  Instr/op are valid for decode this cycle
fetch_err  out  1  sticky error flag: misaligned target or timeout

Behaviour:
- States: REQ, HOLD, ERR. Registers: state, PC, Instr, wait_cnt (8 bit), fetch_err.
- Reset (reset=1 at an edge) applies in any state, including mid-REQ or HOLD. It loads:
  - state=REQ, PC=RESET_PC, Instr=32'h0000_0013 (NOP), wait_cnt=0, fetch_err=0.
  - While reset is high, imem_req and instr_valid are forced to 0.
  - An outstanding memory request is abandoned; a stale imem_ready seen during reset is ignored.
- Combinational outputs:
  - imem_req = (state==REQ) && !reset.
  - imem_addr = PC.
  - instr_valid = (state==HOLD) && !reset.
  - op = Instr[6:0].
  - PCPlus4 = PC + 4, modulo 2^XLEN (wraps; 32'hFFFF_FFFC + 4 = 0).
- REQ:
  - If imem_ready=1: Instr <= imem_rdata, wait_cnt <= 0, go to HOLD.
  - Else if wait_cnt == MAX_WAIT-1: fetch_err <= 1, go to ERR.
  - Else: wait_cnt <= wait_cnt + 1.
  - Zero-wait memory: the request cycle is followed by a HOLD cycle, so throughput is one instruction per 2 cycles.
- HOLD, stall_in=1:
  - Stay in HOLD. PC, Instr and instr_valid are unchanged; PCSrc and PCTarget are ignored.
- HOLD, stall_in=0:
  - next = PCSrc ? PCTarget : PCPlus4.
  - If next[1:0] != 2'b00: fetch_err <= 1, go to ERR, PC unchanged.
  - Else: PC <= next, go to REQ.
- ERR:
  - imem_req=0, instr_valid=0, fetch_err=1.
  - All registers hold; only reset exits ERR.
- imem_ready while imem_req=0 is ignored (no capture, no state change).
- imem_rdata is never inspected for legality. Unknown opcodes pass through to the decoder unchanged.
- Each fetch issues exactly one request and captures exactly one word. A request never spans a PC change.

Test Plan:
- Reset release with RESET_PC=0 and zero-wait memory returning 0x00500093 at addr 0, PCSrc=0:
  - Cycle 1: imem_req=1, addr=0.
  - Cycle 2: instr_valid=1, Instr=0x00500093, op=7'b0010011.
  - Cycle 3: imem_addr=4.
- Branch: in HOLD at PC=0x10, drive PCSrc=1, PCTarget=0x40 -> next REQ has imem_addr=0x40; PCPlus4 reads 0x44 after capture.
- Wait states: memory with 3-cycle latency -> imem_req high for 4 cycles with addr stable; Instr captured only on the ready cycle; no error. MAX_WAIT=15 with ready never asserted -> fetch_err=1 after the 15th REQ cycle, imem_req=0, state held until reset.
- Stall: stall_in=1 for 5 cycles in HOLD with PCSrc toggling -> Instr, PC and instr_valid=1 constant; PC advances by 4 only after stall_in drops.
- Misaligned target: PCSrc=1, PCTarget=0x102 -> fetch_err=1, no further imem_req, PC remains at old value. Then reset=1 for one cycle -> fetch_err=0, PC=RESET_PC, imem_req=1 the cycle after reset drops.
- Wrap and mid-op reset:
  - PC=0xFFFFFFFC, PCSrc=0 -> next imem_addr=0x0.
  - Assert reset during a REQ wait -> pending ready ignored, Instr=0x00000013, instr_valid=0.
